jk_bank_ctrl: RTL and testbench
===============================

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, number of JK cells in the controlled bank.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req_valid  input  1  a command is present on op/data.
REQ-005 req_ready  output  1  the controller can accept a command.
REQ-006 op  input  3  command code: 0 HOLD, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 COUNT, 6-7 illegal.
REQ-007 data  input  WIDTH  LOAD value, TOGGLE mask, or COUNT step count.
REQ-008 q  output  WIDTH  bank outputs, one JK cell per bit.
REQ-009 qn  output  WIDTH  complement of q, bit for bit.
REQ-010 busy  output  1  a command is in progress (state is not IDLE).
REQ-011 done  output  1  one-cycle pulse at command completion.
REQ-012 err  output  1  one-cycle pulse, coincident with done, for an illegal op.

Function
REQ-013 FSM states are IDLE, APPLY, COUNT and DONE; req_ready SHALL equal (state==IDLE).
REQ-014 A command is accepted on an edge where req_valid & req_ready; op and data SHALL be captured into internal registers on that edge.
REQ-015 Commands offered while req_ready=0 SHALL be ignored and not queued; req_valid may stay high without side effects.
REQ-016 On acceptance of ops 0-4 or 6-7: IDLE->APPLY; APPLY->DONE after exactly one cycle.
REQ-017 On acceptance of COUNT with data!=0: IDLE->COUNT. With data==0: IDLE->DONE, and q is unchanged.
REQ-018 Per-bit J/K drive during APPLY:
- HOLD: J=0, K=0.
- CLEAR: J=0, K=1.
- SET: J=1, K=0.
- LOAD: J=d, K=~d.
- TOGGLE: J=K=mask bit.
- illegal: same as HOLD.
REQ-019 While not in APPLY or COUNT, every cell SHALL be driven J=0, K=0 (hold).
REQ-020 q SHALL reflect the APPLY result on the edge that leaves APPLY. Latency from the accept edge to the updated q is 2 edges.
REQ-021 In COUNT, each cycle SHALL drive J=K=carry, where carry[0]=1 and carry[i]=&q[i-1:0]. q increments by 1 per edge, modulo 2^WIDTH (wraps 2^WIDTH-1 -> 0).
REQ-022 A step counter loaded with data SHALL decrement each COUNT cycle. COUNT->DONE on the edge where the last step executes, so exactly data increments occur.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go DONE->IDLE. err=1 in DONE only if the captured op was 6 or 7.
REQ-024 qn SHALL always equal ~q, with no cycle of skew.

Reset
REQ-025 On rst=1 at an edge: state=IDLE, q=0, qn=all ones, step counter=0, captured op/data=0, done=0, err=0, busy=0, req_ready=1 from the following cycle.
REQ-026 Reset SHALL take priority over every command and state, including mid-APPLY and mid-COUNT. The aborted command produces no done pulse.
REQ-027 A command presented on the same edge as rst=1 SHALL NOT be accepted.

Structure
REQ-028 Package jk_bank_pkg SHALL hold the op-code constants, the FSM state encoding and the default WIDTH.
REQ-029 Each bank bit SHALL be an instance of sub-module jk_cell: 1-bit JK flip-flop with clk, synchronous active-high rst, j and k inputs, q and qn outputs.
REQ-030 jk_cell behaviour: 00 hold, 01 reset to 0, 10 set to 1, 11 toggle.

Verification
REQ-031 Reset, then LOAD data=4'b1010 -> done pulses 2 edges after acceptance; q=1010, qn=0101, err=0.
REQ-032 From q=1010, TOGGLE mask=4'b0110 -> q=1100. Then SET -> q=1111. Then CLEAR -> q=0000.
REQ-033 LOAD 4'b1101, then COUNT data=5 -> q sequence 1110, 1111, 0000, 0001, 0010 (wrap); done on the 5th increment edge; busy high throughout.
REQ-034 COUNT data=0 -> done one edge after acceptance; q unchanged. Op 7 -> q unchanged, done=1 and err=1 in the same cycle.
REQ-035 Hold req_valid high during COUNT data=8 with a different op -> no second acceptance until IDLE; rst asserted after 3 increments -> q=0, no done, req_ready=1 on the next cycle.

Source files
------------

// File: rtl/jk_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_bank_pkg : op codes, FSM encoding and defaults for jk_bank_ctrl  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package jk_bank_pkg;

    localparam int JK_DEFAULT_WIDTH = 4;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_COUNT  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic op_is_illegal(input logic [2:0] o);
        return (o >= 3'd6);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bank_ctrl_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_cell : single JK flip-flop (00 hold, 01 clear, 10 set, 11 tgl)  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jk_bank_ctrl : command FSM driving a bank of JK cells (apply/count) |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jk_bank_ctrl
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = JK_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] w_j, w_k, w_carry;
    logic             w_accept;

    assign req_ready = (state_q == S_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = done & op_is_illegal(op_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d   = op;
                    data_d = data;
                    if (op == OP_COUNT) begin
                        step_d  = data;
                        state_d = (data != '0) ? S_COUNT : S_DONE;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
            end
            S_APPLY: state_d = S_DONE;
            S_COUNT: begin
                // Leave on the edge that executes the last increment.
                step_d = step_q - WIDTH'(1);
                if (step_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // carry[i] = AND of all lower q bits; bit 0 always toggles.
    always_comb begin
        w_carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i] = &(q | ~((WIDTH'(1) << i) - WIDTH'(1)));
        end
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (state_q == S_APPLY) begin
            case (op_q)
                OP_CLEAR:  w_k = '1;
                OP_SET:    w_j = '1;
                OP_LOAD: begin
                    w_j = data_q;
                    w_k = ~data_q;
                end
                OP_TOGGLE: begin
                    w_j = data_q;
                    w_k = data_q;
                end
                default: begin
                    w_j = '0;
                    w_k = '0;
                end
            endcase
        end else if (state_q == S_COUNT) begin
            w_j = w_carry;
            w_k = w_carry;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (w_j[g]),
            .k   (w_k[g]),
            .q   (q[g]),
            .qn  (qn[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jk_bank_ctrl : directed + random bench with a schedule model    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_jk_bank_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] data = '0;
    logic [W-1:0] q, qn;
    logic         busy, done, err;

    int n_assert = 0;
    int n_fail   = 0;

    jk_bank_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .data      (data),
        .q         (q),
        .qn        (qn),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Model: every accepted command expands into the list of output
    // snapshots it must produce after each following edge.
    typedef struct {
        logic [W-1:0] q;
        bit           busy;
        bit           done;
        bit           err;
    } exp_t;

    exp_t         pend[$];
    exp_t         cur;
    logic [W-1:0] m_q = '0;
    bit           model_valid = 0;

    function automatic void build(input logic [2:0] o, input logic [W-1:0] d);
        logic [W-1:0] old;
        logic [W-1:0] nw;
        old = m_q;
        if (o == 3'd5) begin
            for (int k = 0; k < int'(d); k++) pend.push_back('{old + W'(k), 1, 0, 0});
            nw = old + d;
            pend.push_back('{nw, 1, 1, 0});
        end else begin
            case (o)
                3'd1:    nw = '0;
                3'd2:    nw = '1;
                3'd3:    nw = d;
                3'd4:    nw = old ^ d;
                default: nw = old;
            endcase
            pend.push_back('{old, 1, 0, 0});
            pend.push_back('{nw, 1, 1, (o >= 3'd6)});
        end
        m_q = nw;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            m_q = '0;
            cur = '{'0, 0, 0, 0};
            model_valid = 1;
        end else if (pend.size() > 0) begin
            cur = pend.pop_front();
        end else if (!cur.busy && req_valid) begin
            build(op, data);
            cur = pend.pop_front();
        end else begin
            cur = '{m_q, 0, 0, 0};
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            n_assert++;
            if (q !== cur.q || qn !== ~cur.q || busy !== cur.busy ||
                req_ready !== !cur.busy || done !== cur.done || err !== cur.err) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got q=%b qn=%b busy=%b rdy=%b done=%b err=%b exp q=%b qn=%b busy=%b rdy=%b done=%b err=%b",
                         $time, q, qn, busy, req_ready, done, err,
                         cur.q, ~cur.q, cur.busy, !cur.busy, cur.done, cur.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    logic [W-1:0] seen[$];

    // Issues one command, leaves the bench in the cycle where done is high.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] d, output int lat);
        int guard;
        lat = -1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("wait_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        op = o;
        data = d;
        tick();
        req_valid = 1'b0;
        seen.delete();
        seen.push_back(q);
        if (done) begin
            lat = 0;
        end else begin
            for (int t = 1; t <= 40; t++) begin
                tick();
                seen.push_back(q);
                if (done) begin
                    lat = t;
                    break;
                end
            end
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] cnt_exp [5];
        cnt_exp = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_qn", 32'(qn), 32'hF);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);

        issue(3'd3, 4'b1010, lat);
        chk("load_latency", 32'(lat), 32'd1);
        chk("load_q", 32'(q), 32'hA);
        chk("load_qn", 32'(qn), 32'h5);
        chk("load_err", 32'(err), 32'd0);
        tick();

        issue(3'd4, 4'b0110, lat);
        chk("toggle_q", 32'(q), 32'hC);
        tick();
        issue(3'd2, 4'b0000, lat);
        chk("set_q", 32'(q), 32'hF);
        tick();
        issue(3'd1, 4'b0000, lat);
        chk("clear_q", 32'(q), 32'h0);
        tick();

        issue(3'd3, 4'b1101, lat);
        tick();
        issue(3'd5, 4'd5, lat);
        chk("count5_latency", 32'(lat), 32'd5);
        if (seen.size() == 6) begin
            for (int k = 0; k < 5; k++) chk($sformatf("count5_q%0d", k + 1), 32'(seen[k + 1]), 32'(cnt_exp[k]));
        end
        tick();

        issue(3'd5, 4'd0, lat);
        chk("count0_latency", 32'(lat), 32'd0);
        chk("count0_q", 32'(q), 32'h2);
        tick();

        issue(3'd7, 4'b1001, lat);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_done", 32'(done), 32'd1);
        chk("illegal_q", 32'(q), 32'h2);
        tick();

        // Long count with a second command held on the bus, then reset mid-count.
        req_valid = 1'b1;
        op = 3'd5;
        data = 4'd8;
        tick();
        op = 3'd3;
        data = 4'd3;
        tick();
        tick();
        tick();
        chk("count8_mid_q", 32'(q), 32'h5);
        chk("count8_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        chk("abort_no_done", 32'(done), 32'd0);

        for (int c = 0; c < 500; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = $urandom_range(0, 1);
            op        = 3'($urandom_range(0, 7));
            data      = W'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < 20; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
